v21_pulse_ctrl: RTL
===================

// Module: v21_pulse_ctrl
// PURPOSE
// Sequencer/scheduler for the v21 trapezoidal shaping filter. Owns the filter's reset (flush + settle), arms
// a threshold trigger on the shaped output, samples the flat-top amplitude a programmable delay after trigger,
// and hands timestamped events downstream over valid/ready. Sits between v21_filter and the event readout.
// PARAMETERS
// DATA_W    16   width of filt_data/ev_amp (= SIZE_FILTER_DATA), signed two's complement
// TS_W      32   timestamp counter width
// SETTLE    64   cycles after filter flush before arming; must be >= v21_k+v21_l+4 (filter pipeline depth)
// CNT_W     8    width of cfg_flat / cfg_holdoff counters
// PORTS
// clk            in   1        system clock
// reset          in   1        asynchronous, active-low reset
// soft_clear     in   1        1-cycle request: flush filter and restart sequence
// cfg_threshold  in   DATA_W   signed trigger level, used live
// cfg_flat       in   CNT_W    trigger-to-sample delay, sampled at trigger
// cfg_holdoff    in   CNT_W    dead time after event accept, sampled at handshake
// filt_data      in   DATA_W   v21_filter output_data (signed)
// filt_rst_n     out  1        active-low reset to v21_filter
// ev_valid       out  1        event available
// ev_ready       in   1        downstream accepts event
// ev_amp         out  DATA_W   sampled amplitude
// ev_ts          out  TS_W     timestamp of trigger cycle
// ev_pileup      out  1        second crossing seen between trigger and sample
// busy           out  1        1 in CLEAR/SETTLE (not armed for triggers)
// drop_cnt       out  16       saturating count of lost triggers/discarded events
// BEHAVIOUR
// - Reset (async, reset=0): state CLEAR, filt_rst_n=0, ev_valid=0, ev_amp=0, ev_ts=0, ev_pileup=0, busy=1,
//   drop_cnt=0, ts=0, prev_above=1. Reset mid-operation aborts everything; pending event is lost, not counted.
// - ts: free-running, +1 every cycle after reset, wraps 2^TS_W-1 -> 0 silently.
// - Crossing: above = (signed filt_data > cfg_threshold); xing = above & !prev_above; prev_above <= above
//   in ARMED/FLAT/EMIT/HOLDOFF; forced 1 in CLEAR/SETTLE so a level already high at arming never triggers.
// - FSM:
//   CLEAR   filt_rst_n=0 for exactly 2 cycles -> SETTLE.
//   SETTLE  filt_rst_n=1, count SETTLE cycles -> ARMED. busy=1 in CLEAR/SETTLE, else 0.
//   ARMED   on xing: ev_ts<=ts, cnt<=cfg_flat, pileup<=0 -> FLAT.
//   FLAT    xing -> pileup<=1. cnt==0: ev_amp<=filt_data, ev_pileup<=pileup|xing, ev_valid<=1 -> EMIT;
//           else cnt--. Amplitude = filt_data from cycle trigger+cfg_flat+1.
//   EMIT    ev_valid=1, ev_amp/ev_ts/ev_pileup held stable until ev_valid&ev_ready. xing here -> drop_cnt++.
//           On handshake: ev_valid<=0; cnt<=cfg_holdoff; cfg_holdoff==0 -> ARMED, else HOLDOFF.
//   HOLDOFF xing -> drop_cnt++. cnt==1 -> ARMED, else cnt--. Total dead time = cfg_holdoff cycles.
// - soft_clear: highest priority, any state -> CLEAR next cycle; ev_valid<=0. Drops an un-accepted event
//   (drop_cnt++) even if ev_ready is high in that cycle. soft_clear during CLEAR restarts the 2-cycle pulse.
// - drop_cnt saturates at 16'hFFFF; xing and soft_clear discard in one cycle counts +1 only.
// - Output latency: ev_valid rises cfg_flat+2 cycles after the crossing sample appears on filt_data.
// STRUCTURE
// - Shared package v21_ctrl_pkg: typedef enum logic[2:0] {CLEAR,SETTLE,ARMED,FLAT,EMIT,HOLDOFF}
//   v21_ctrl_state_t; localparam V21_SETTLE_MIN = v21_k+v21_l+4; DATA_W from SIZE_FILTER_DATA.
// - One sub-module: v21_xing_det (prev_above register + signed compare, force input for CLEAR/SETTLE).
// - FSM, counters, timestamp and event registers in v21_pulse_ctrl; all regs on posedge clk/negedge reset.
// TESTING
// - Reset release: filt_rst_n low exactly 2 cycles, busy=1 for 2+64 cycles, ev_valid stays 0.
// - Thr=100, flat=5: step filt_data 0->300 at ts=200 -> ev_ts=200, ev_amp=filt_data@206, pileup=0.
// - Pile-up: thr=100, flat=10, crossings at t0 and t0+4 -> ev_pileup=1, single event.
// - Backpressure: ev_ready=0 for 50 cycles, 3 crossings meanwhile -> payload stable, drop_cnt=3.
// - Holdoff=20: crossing 10 cycles after accept -> drop_cnt+1; crossing 25 cycles after -> new event.
// - soft_clear while ev_valid=1 -> ev_valid=0 next cycle, drop_cnt+1, CLEAR/SETTLE re-run; input held
//   above thr through arming -> no trigger.

Source files
------------

// File: rtl/v21_ctrl_pkg.sv
// Shared types and constants for the v21 pulse controller.
package v21_ctrl_pkg;

  localparam int SIZE_FILTER_DATA = 16;
  // Trapezoid rise (k) and flat (l) lengths of the companion filter.
  localparam int v21_k            = 16;
  localparam int v21_l            = 8;
  // Shortest settle window that lets the filter pipeline drain after a flush.
  localparam int V21_SETTLE_MIN   = v21_k + v21_l + 4;

  localparam int DATA_W     = SIZE_FILTER_DATA;
  localparam int TS_W       = 32;
  localparam int CNT_W      = 8;
  localparam int SETTLE_CYC = 64;
  localparam int DROP_W     = 16;

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    SETTLE  = 3'd1,
    ARMED   = 3'd2,
    FLAT    = 3'd3,
    EMIT    = 3'd4,
    HOLDOFF = 3'd5
  } v21_ctrl_state_t;

  // The controller is not accepting triggers while the filter is flushed or settling.
  function automatic logic is_busy(input v21_ctrl_state_t s);
    return (s == CLEAR) || (s == SETTLE);
  endfunction

endpackage

// File: rtl/v21_xing_det.sv
// Rising threshold-crossing detector on the signed shaped output.
// While force_i is high the previous-above flag is held at 1, so a level that is
// already above threshold when the controller arms never counts as a crossing.
module v21_xing_det
  import v21_ctrl_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] data_i,
  input  logic signed [W-1:0] thr_i,
  input  logic                force_i,
  output logic                above_o,
  output logic                xing_o
);

  logic prev_above_q;
  logic prev_above_d;

  assign above_o      = (data_i > thr_i);
  assign xing_o       = above_o & ~prev_above_q & ~force_i;
  assign prev_above_d = force_i | above_o;

  // Remember last cycle's comparison result (forced high while not armed).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_above_q <= 1'b1;
    else        prev_above_q <= prev_above_d;
  end

endmodule

// File: rtl/v21_pulse_ctrl.sv
// Sequencer for the v21 trapezoidal filter: flushes and settles the filter, arms a
// threshold trigger, samples the flat-top amplitude cfg_flat+1 cycles after the
// trigger and presents a timestamped event downstream.
//
// Event handshake: ev_valid rises with a complete payload; ev_amp, ev_ts and
// ev_pileup stay frozen while ev_valid is high; the event is consumed on a cycle
// where ev_valid & ev_ready are both high, and ev_valid never drops without that
// except on soft_clear (which discards and counts the event).
module v21_pulse_ctrl
  import v21_ctrl_pkg::*;
#(
  parameter int DATA_W     = v21_ctrl_pkg::DATA_W,
  parameter int TS_W       = v21_ctrl_pkg::TS_W,
  parameter int SETTLE_CYC = v21_ctrl_pkg::SETTLE_CYC,
  parameter int CNT_W      = v21_ctrl_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     soft_clear,
  input  logic signed [DATA_W-1:0] cfg_threshold,
  input  logic        [CNT_W-1:0]  cfg_flat,
  input  logic        [CNT_W-1:0]  cfg_holdoff,
  input  logic signed [DATA_W-1:0] filt_data,
  output logic                     filt_rst_n,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic signed [DATA_W-1:0] ev_amp,
  output logic        [TS_W-1:0]   ev_ts,
  output logic                     ev_pileup,
  output logic                     busy,
  output logic        [DROP_W-1:0] drop_cnt,
  output v21_ctrl_state_t          dbg_state
);

  // One shared down-counter covers the flush, settle, flat and holdoff phases.
  localparam int SET_W = $clog2(SETTLE_CYC);
  localparam int CW    = (CNT_W > SET_W) ? CNT_W : SET_W;

  v21_ctrl_state_t          state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [TS_W-1:0]          ts_q, ts_d;
  logic                     pileup_q, pileup_d;
  logic                     ev_valid_q, ev_valid_d;
  logic signed [DATA_W-1:0] ev_amp_q, ev_amp_d;
  logic [TS_W-1:0]          ev_ts_q, ev_ts_d;
  logic                     ev_pileup_q, ev_pileup_d;
  logic [DROP_W-1:0]        drop_q, drop_d;
  logic                     filt_rst_n_q, filt_rst_n_d;
  logic                     busy_q, busy_d;
  logic                     above;
  logic                     xing;
  logic                     drop_inc;

  v21_xing_det #(.W(DATA_W)) u_xing (
    .clk     (clk),
    .reset   (reset),
    .data_i  (filt_data),
    .thr_i   (cfg_threshold),
    .force_i (is_busy(state_q)),
    .above_o (above),
    .xing_o  (xing)
  );

  // Next-state, counter and event payload logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pileup_d    = pileup_q;
    ev_valid_d  = ev_valid_q;
    ev_amp_d    = ev_amp_q;
    ev_ts_d     = ev_ts_q;
    ev_pileup_d = ev_pileup_q;
    ts_d        = ts_q + TS_W'(1);

    // A crossing while an event is pending or during dead time is lost; a flush
    // with an unconsumed event discards it. Both in one cycle count once.
    drop_inc = (xing && ((state_q == EMIT) || (state_q == HOLDOFF))) ||
               (soft_clear && ev_valid_q);

    if (soft_clear) begin
      state_d    = CLEAR;
      cnt_d      = CW'(1);
      ev_valid_d = 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (cnt_q == '0) begin
            state_d = SETTLE;
            cnt_d   = CW'(SETTLE_CYC - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == '0) state_d = ARMED;
          else             cnt_d   = cnt_q - CW'(1);
        end
        ARMED: begin
          if (xing) begin
            ev_ts_d  = ts_q;
            cnt_d    = CW'(cfg_flat);
            pileup_d = 1'b0;
            state_d  = FLAT;
          end
        end
        FLAT: begin
          if (xing) pileup_d = 1'b1;
          if (cnt_q == '0) begin
            ev_amp_d    = filt_data;
            ev_pileup_d = pileup_q | xing;
            ev_valid_d  = 1'b1;
            state_d     = EMIT;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        EMIT: begin
          if (ev_ready) begin
            ev_valid_d = 1'b0;
            cnt_d      = CW'(cfg_holdoff);
            state_d    = (cfg_holdoff == '0) ? ARMED : HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (cnt_q == CW'(1)) state_d = ARMED;
          else                 cnt_d   = cnt_q - CW'(1);
        end
        default: begin
          state_d = CLEAR;
          cnt_d   = CW'(1);
        end
      endcase
    end

    drop_d       = (drop_inc && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
    filt_rst_n_d = (state_d != CLEAR);
    busy_d       = is_busy(state_d);
  end

  // State, counters, timestamp and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CLEAR;
      cnt_q        <= CW'(1);
      ts_q         <= '0;
      pileup_q     <= 1'b0;
      ev_valid_q   <= 1'b0;
      ev_amp_q     <= '0;
      ev_ts_q      <= '0;
      ev_pileup_q  <= 1'b0;
      drop_q       <= '0;
      filt_rst_n_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ts_q         <= ts_d;
      pileup_q     <= pileup_d;
      ev_valid_q   <= ev_valid_d;
      ev_amp_q     <= ev_amp_d;
      ev_ts_q      <= ev_ts_d;
      ev_pileup_q  <= ev_pileup_d;
      drop_q       <= drop_d;
      filt_rst_n_q <= filt_rst_n_d;
      busy_q       <= busy_d;
    end
  end

  assign filt_rst_n = filt_rst_n_q;
  assign ev_valid   = ev_valid_q;
  assign ev_amp     = ev_amp_q;
  assign ev_ts      = ev_ts_q;
  assign ev_pileup  = ev_pileup_q;
  assign busy       = busy_q;
  assign drop_cnt   = drop_q;
  assign dbg_state  = state_q;

endmodule
